// File: rtl/intpol2_D4_pkg.sv
// Shared types and constants for the order-2, factor-4 interpolator controller.
package intpol2_D4_pkg;

    localparam int PHASES    = 4;
    localparam int PRELOAD_N = 3;
    localparam int MIN_ILEN  = 3;

    localparam int PHASE_W = $clog2(PHASES);
    localparam int PRE_W   = $clog2(PRELOAD_N);

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [PRE_W-1:0]   pre_cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_PRELOAD,
        S_INTERP,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/intpol2_D4_wr_pipe.sv
// Write-valid delay line: a step issued at cycle t presents out_vld at t+PIPE_LAT.
module intpol2_D4_wr_pipe #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld,
    output logic empty
);

    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] vld_d;

    // The cast drops the oldest stage, which also covers PIPE_LAT == 1.
    always_comb begin
        if (flush) vld_d = '0;
        else       vld_d = PIPE_LAT'({vld_q, in_vld});
    end

    // NOTE: this shift register is reset because out_vld drives a real FIFO push and
    // empty gates DRAIN; X in any stage after reset would leak straight to the outputs.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign out_vld = vld_q[PIPE_LAT-1];
    assign empty   = ~|vld_q;

endmodule

// File: rtl/intpol2_d4_ctrl_fsm.sv
// Sequencing controller for the order-2, factor-4 interpolator datapath.
// Optional stall statistics ports are built when INTPOL2_D4_STATS_EN is defined.
module intpol2_d4_ctrl_fsm
    import intpol2_D4_pkg::*;
#(
    parameter int CONFIG_WIDTH = 32,
    parameter int PIPE_LAT     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CONFIG_WIDTH-1:0] ilen,
    input  logic                    Empty,
    input  logic                    Afull,
    input  logic                    comp_cnt,
    output logic                    busy,
    output logic                    clear,
    output logic                    Read_Enable,
    output logic                    en_M_addr,
    output logic                    en_sum,
    output logic [1:0]              sel_xi2,
    output logic                    Write_Enable,
    output logic                    done,
    output logic                    cfg_err
`ifdef INTPOL2_D4_STATS_EN
    ,
    output logic [CONFIG_WIDTH-1:0] stall_empty_cnt,
    output logic [CONFIG_WIDTH-1:0] stall_afull_cnt
`endif
);

    state_t   state_q, state_d;
    phase_t   phase_q, phase_d;
    pre_cnt_t pre_cnt_q, pre_cnt_d;

    logic issue;
    logic pipe_empty;
    logic ilen_ok;

    assign ilen_ok = (ilen >= CONFIG_WIDTH'(MIN_ILEN));

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            pre_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pre_cnt_d = pre_cnt_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:    if (start && ilen_ok) state_d = S_CLR;
                S_CLR: begin
                    state_d   = S_PRELOAD;
                    pre_cnt_d = '0;
                    phase_d   = '0;
                end
                S_PRELOAD: if (!Empty) begin
                    pre_cnt_d = pre_cnt_q + pre_cnt_t'(1);
                    if (pre_cnt_q == pre_cnt_t'(PRELOAD_N - 1)) state_d = S_INTERP;
                end
                S_INTERP:  if (!Afull) begin
                    phase_d = phase_q + phase_t'(1);
                    if (phase_q == phase_t'(PHASES - 1)) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (comp_cnt) begin
                        state_d = S_DRAIN;
                    end else if (!Empty) begin
                        state_d = S_INTERP;
                        phase_d = '0;
                    end
                end
                S_DRAIN:   if (pipe_empty) state_d = S_DONE;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Abort suppresses every same-cycle action except the counter clear.
    always_comb begin
        busy        = state_q inside {S_CLR, S_PRELOAD, S_INTERP, S_SHIFT, S_DRAIN};
        clear       = 1'b0;
        Read_Enable = 1'b0;
        en_M_addr   = 1'b0;
        en_sum      = 1'b0;
        sel_xi2     = '0;
        issue       = 1'b0;
        done        = 1'b0;
        cfg_err     = 1'b0;
        if (abort) begin
            clear = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE:    cfg_err = start && !ilen_ok;
                S_CLR:     clear = 1'b1;
                S_PRELOAD: if (!Empty) begin
                    Read_Enable = 1'b1;
                    en_M_addr   = 1'b1;
                    en_sum      = (pre_cnt_q != '0);
                end
                S_INTERP:  if (!Afull) begin
                    issue   = 1'b1;
                    sel_xi2 = phase_q;
                end
                S_SHIFT:   if (!comp_cnt && !Empty) begin
                    Read_Enable = 1'b1;
                    en_M_addr   = 1'b1;
                    en_sum      = 1'b1;
                end
                S_DONE:    done = 1'b1;
                default:   ;
            endcase
        end
    end

    intpol2_D4_wr_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_wr_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .in_vld  (issue),
        .out_vld (Write_Enable),
        .empty   (pipe_empty)
    );

`ifdef INTPOL2_D4_STATS_EN
    logic [CONFIG_WIDTH-1:0] se_q, se_d, sa_q, sa_d;
    logic stall_e, stall_a;

    assign stall_e = (state_q == S_PRELOAD && Empty) ||
                     (state_q == S_SHIFT && !comp_cnt && Empty);
    assign stall_a = (state_q == S_INTERP && Afull);

    always_comb begin
        se_d = se_q;
        sa_d = sa_q;
        if (state_q == S_CLR) begin
            se_d = '0;
            sa_d = '0;
        end else if (!abort) begin
            if (stall_e && se_q != '1) se_d = se_q + CONFIG_WIDTH'(1);
            if (stall_a && sa_q != '1) sa_d = sa_q + CONFIG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            se_q <= '0;
            sa_q <= '0;
        end else begin
            se_q <= se_d;
            sa_q <= sa_d;
        end
    end

    assign stall_empty_cnt = se_q;
    assign stall_afull_cnt = sa_q;
`endif

endmodule

// File: tb/tb_intpol2_d4_ctrl_fsm.sv
// Self-checking bench: a job-level operation-list model predicts every output each cycle.
module tb_intpol2_d4_ctrl_fsm;

    localparam int CW  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic          Empty = 1'b1, Afull = 1'b0, comp_cnt = 1'b0;
    logic [CW-1:0] ilen = '0;
    logic          busy, clear, Read_Enable, en_M_addr, en_sum, Write_Enable, done, cfg_err;
    logic [1:0]    sel_xi2;
`ifdef INTPOL2_D4_STATS_EN
    logic [CW-1:0] stall_empty_cnt, stall_afull_cnt;
`endif

    intpol2_d4_ctrl_fsm #(.CONFIG_WIDTH(CW), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ilen(ilen),
        .Empty(Empty), .Afull(Afull), .comp_cnt(comp_cnt),
        .busy(busy), .clear(clear), .Read_Enable(Read_Enable), .en_M_addr(en_M_addr),
        .en_sum(en_sum), .sel_xi2(sel_xi2), .Write_Enable(Write_Enable), .done(done),
        .cfg_err(cfg_err)
`ifdef INTPOL2_D4_STATS_EN
        , .stall_empty_cnt(stall_empty_cnt), .stall_afull_cnt(stall_afull_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Job model: a run is a fixed list of operations, each consuming one cycle once
    // its FIFO condition allows; writes are due LAT cycles after each issue.
    typedef enum {M_IDLE, M_CLR, M_RUN, M_DRAIN, M_DONE} mst_t;
    typedef enum {K_RD, K_ISS, K_END} kind_t;
    typedef struct { kind_t kind; int arg; int win; } op_t;  // RD arg: 0 first, 1 preload, 2 slide

    op_t  ops[$];
    int   due[$];
    mst_t ms = M_IDLE;
    int   last_due = -1, job_ilen = 0, cnt = 0, m_se = 0, m_sa = 0;
    int   p_empty = 0, p_afull = 0, hold_pre = 0, hold_shift = 0, hold_af = 0;
    int   n_rd, n_wr, n_done, n_es, n_busy;

    task automatic build_ops(input int n);
        ops.delete();
        for (int i = 0; i < 3; i++) ops.push_back('{kind: K_RD, arg: (i == 0) ? 0 : 1, win: 0});
        for (int w = 0; w <= n - 3; w++) begin
            for (int p = 0; p < 4; p++) ops.push_back('{kind: K_ISS, arg: p, win: w});
            if (w < n - 3) ops.push_back('{kind: K_RD, arg: 2, win: w});
            else           ops.push_back('{kind: K_END, arg: 0, win: w});
        end
    endtask

    task automatic tick(input logic st, input logic ab, input logic rs);
        logic e, a;
        logic e_busy, e_clear, e_re, e_es, e_we, e_done, e_cfg;
        logic [1:0] e_sel;
        mst_t nxt;
        @(posedge clk); #1;
        e = ($urandom_range(99) < p_empty);
        a = ($urandom_range(99) < p_afull);
        if (ms == M_RUN && ops.size() > 0) begin
            if (ops[0].kind == K_RD && ops[0].arg < 2 && hold_pre > 0) begin
                e = 1'b1; hold_pre--;
            end else if (ops[0].kind == K_RD && ops[0].arg == 2 && hold_shift > 0) begin
                e = 1'b1; hold_shift--;
            end else if (ops[0].kind == K_ISS && ops[0].arg == 2 && hold_af > 0) begin
                a = 1'b1; hold_af--;
            end
        end
        start = st; abort = ab; rst = rs; Empty = e; Afull = a;
        ilen = CW'(job_ilen);
        comp_cnt = (cnt >= job_ilen - 1);
        @(negedge clk);

        e_busy = (ms == M_CLR || ms == M_RUN || ms == M_DRAIN);
        {e_clear, e_re, e_es, e_we, e_done, e_cfg} = '0;
        e_sel = 2'd0;
        nxt = ms;
        if (due.size() > 0 && due[0] == cyc) begin
            e_we = 1'b1;
            void'(due.pop_front());
        end
        if (ab) begin
            e_clear = 1'b1;
            nxt = M_IDLE;
            ops.delete();
            due.delete();
        end else begin
            case (ms)
                M_IDLE: if (st) begin
                    if (job_ilen < 3) e_cfg = 1'b1;
                    else begin nxt = M_CLR; build_ops(job_ilen); end
                end
                M_CLR: begin e_clear = 1'b1; nxt = M_RUN; m_se = 0; m_sa = 0; end
                M_RUN: begin
                    case (ops[0].kind)
                        K_RD: if (!e) begin
                            e_re = 1'b1; e_es = (ops[0].arg != 0);
                            void'(ops.pop_front());
                        end else m_se++;
                        K_ISS: if (!a) begin
                            e_sel = 2'(ops[0].arg);
                            due.push_back(cyc + LAT);
                            last_due = cyc + LAT;
                            void'(ops.pop_front());
                        end else m_sa++;
                        default: void'(ops.pop_front());
                    endcase
                    if (ops.size() == 0) nxt = M_DRAIN;
                end
                M_DRAIN: if (cyc > last_due) nxt = M_DONE;
                default: begin e_done = 1'b1; nxt = M_IDLE; end
            endcase
        end

        if (!rs) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("clear", 32'(clear), 32'(e_clear));
            check("read_enable", 32'(Read_Enable), 32'(e_re));
            check("en_m_addr", 32'(en_M_addr), 32'(e_re));
            check("en_sum", 32'(en_sum), 32'(e_es));
            check("sel_xi2", 32'(sel_xi2), 32'(e_sel));
            check("write_enable", 32'(Write_Enable), 32'(e_we));
            check("done", 32'(done), 32'(e_done));
            check("cfg_err", 32'(cfg_err), 32'(e_cfg));
        end
        n_rd += int'(Read_Enable); n_wr += int'(Write_Enable);
        n_done += int'(done); n_es += int'(en_sum); n_busy += int'(busy);

        if (rs) begin
            nxt = M_IDLE; ops.delete(); due.delete(); cnt = 0; m_se = 0; m_sa = 0;
        end else if (clear) cnt = 0;
        else if (en_sum) cnt++;
        ms = nxt;
        cyc++;
    endtask

    // Runs one start-to-IDLE job; returns 1 when it completed without abort or reset.
    task automatic run_job(input int n, input bit do_abort, input bit do_rst, output bit normal);
        bit aborted, reset_hit;
        logic ab, rs;
        aborted = 0; reset_hit = 0;
        n_rd = 0; n_wr = 0; n_done = 0; n_es = 0; n_busy = 0;
        job_ilen = n;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3000 && ms != M_IDLE; k++) begin
            ab = do_abort && !aborted && ms == M_RUN && ops.size() > 0 &&
                 ops[0].kind == K_ISS && ops[0].win == 1 && ops[0].arg == 1;
            rs = do_rst && !reset_hit && ms == M_DRAIN;
            aborted |= ab;
            reset_hit |= rs;
            tick(($urandom_range(7) == 0), ab, rs);
        end
        if (ms != M_IDLE) begin
            check("timeout", 32'(0), 32'(1));
            $display("FAIL run_job: bound expired, stopping");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1);
        end
        normal = (n >= 3) && !aborted && !reset_hit;
        if (normal) begin
            check("job_reads", 32'(n_rd), 32'(n));
            check("job_writes", 32'(n_wr), 32'(4 * (n - 2)));
            check("job_en_sum", 32'(n_es), 32'(n - 1));
            check("job_done", 32'(n_done), 32'(1));
        end else if (aborted) begin
            check("abort_done", 32'(n_done), 32'(0));
        end
        tick(1'b0, 1'b0, 1'b0);
`ifdef INTPOL2_D4_STATS_EN
        if (normal) begin
            check("stall_empty", stall_empty_cnt, 32'(m_se));
            check("stall_afull", stall_afull_cnt, 32'(m_sa));
        end
`endif
    endtask

    bit ok;

    initial begin
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        run_job(3, 0, 0, ok);
        run_job(6, 0, 0, ok);

        hold_pre = 5; hold_shift = 4;
        run_job(4, 0, 0, ok);
`ifdef INTPOL2_D4_STATS_EN
        check("stall_empty_9", stall_empty_cnt, 32'd9);
`endif
        hold_af = 6;
        run_job(5, 0, 0, ok);
`ifdef INTPOL2_D4_STATS_EN
        check("stall_afull_6", stall_afull_cnt, 32'd6);
`endif
        hold_pre = 0; hold_shift = 0; hold_af = 0;

        run_job(6, 1, 0, ok);
        check("abort_writes", 32'(n_wr), 32'(4));
        tick(1'b0, 1'b0, 1'b0);
        run_job(3, 0, 0, ok);

        run_job(2, 0, 0, ok);
        check("cfg_busy", 32'(n_busy), 32'(0));

        job_ilen = 4;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        run_job(5, 0, 1, ok);
        tick(1'b0, 1'b0, 1'b0);

        p_empty = 30; p_afull = 30;
        for (int j = 0; j < 12; j++) run_job($urandom_range(9, 3), 0, 0, ok);
        run_job(7, 1, 0, ok);
        run_job($urandom_range(2, 0), 0, 0, ok);
        run_job(4, 0, 0, ok);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
